// File: rtl/mem_stage_hs_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_stage_hs_if
//
// Data-memory port between the memory stage and a variable-latency data memory.
// A request is offered with dmem_req_valid and taken when dmem_req_ready is
// high in the same cycle. One response (read data or write acknowledge) comes
// back later on dmem_rsp_valid.
//
// Signals:
//   dmem_req_valid  stage -> mem  request offered
//   dmem_req_ready  mem -> stage  request taken this cycle
//   dmem_req_addr   stage -> mem  word-aligned byte address (XLEN/8 bytes)
//   dmem_req_we     stage -> mem  1 = write, 0 = read
//   dmem_req_wstrb  stage -> mem  byte strobes, one per byte lane
//   dmem_req_wdata  stage -> mem  write data already placed in its lanes
//   dmem_rsp_valid  mem -> stage  read data returned / write acknowledged
//   dmem_rsp_rdata  mem -> stage  full aligned word
//
// Modports: master = memory stage, slave = data memory.
// XLEN must match the XLEN of the mem_stage_hs instance it connects to.
// -----------------------------------------------------------------------------
interface mem_stage_hs_if #(
  parameter int XLEN = 64
);

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [XLEN-1:0]   dmem_req_addr;
  logic              dmem_req_we;
  logic [XLEN/8-1:0] dmem_req_wstrb;
  logic [XLEN-1:0]   dmem_req_wdata;
  logic              dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_rsp_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_req_addr,
    output dmem_req_we,
    output dmem_req_wstrb,
    output dmem_req_wdata,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_req_addr,
    input  dmem_req_we,
    input  dmem_req_wstrb,
    input  dmem_req_wdata,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rsp_rdata
  );

endinterface

// File: rtl/mem_stage_hs.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_stage_hs
//
// Handshaked memory pipeline stage between EX and WB. It takes one instruction
// per in_valid/in_ready handshake, issues at most one load/store to the data
// memory, aligns and extends load data, and holds the result until WB takes it
// with out_ready. A forwarding bus exposes the pending result to the bypass
// network.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   RF_AW  register-file address width
//   PC_W   program-counter width
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_*              instruction from EX (valid/ready handshake)
//   dmem              data-memory port (mem_stage_hs_if.master)
//   out_*             result to WB (valid/ready handshake)
//   out_misalign      access was misaligned or illegal; no memory access made
//   fwd_rf_we/waddr/wdata  result visible to the bypass network while held
//   fwd_busy          a load is in flight; fwd_rf_waddr names its destination
//
// Flow: IDLE -> (accept) -> REQ -> WAIT -> DONE -> (retire) -> IDLE.
// Non-memory and misaligned instructions go straight from accept to DONE.
// A retire in DONE can accept the next instruction in the same cycle.
// -----------------------------------------------------------------------------
module mem_stage_hs #(
  parameter int XLEN  = 64,
  parameter int RF_AW = 5,
  parameter int PC_W  = 64
) (
  input  logic              clk,
  input  logic              rst,

  // EX side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_ex_result,
  input  logic              in_rf_we,
  input  logic [RF_AW-1:0]  in_rf_waddr,
  input  logic              in_mem_en,
  input  logic              in_mem_we,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_unsigned,
  input  logic [XLEN-1:0]   in_store_data,

  // data memory
  mem_stage_hs_if.master    dmem,

  // WB side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_rf_we,
  output logic [RF_AW-1:0]  out_rf_waddr,
  output logic [XLEN-1:0]   out_rf_wdata,
  output logic              out_misalign,

  // bypass network
  output logic              fwd_rf_we,
  output logic [RF_AW-1:0]  fwd_rf_waddr,
  output logic [XLEN-1:0]   fwd_rf_wdata,
  output logic              fwd_busy
);

  localparam int NB = XLEN / 8;       // bytes per word
  localparam int OW = $clog2(NB);     // byte-offset width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Registered instruction / result fields
  logic [PC_W-1:0]  pc_q;
  logic             rf_we_q;
  logic [RF_AW-1:0] rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q;
  logic             misalign_q;
  logic             is_load_q;
  logic [OW-1:0]    off_q;
  logic [1:0]       size_q;
  logic             uns_q;

  // Registered memory request, held stable for the whole REQ state
  logic [XLEN-1:0]  req_addr_q;
  logic             req_we_q;
  logic [NB-1:0]    req_wstrb_q;
  logic [XLEN-1:0]  req_wdata_q;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction (only used on the accept cycle)
  // ---------------------------------------------------------------------------
  logic [OW-1:0]   in_off;
  logic [OW-1:0]   in_size_mask;
  logic            in_misalign;
  logic [NB-1:0]   in_strb_base;
  logic [NB-1:0]   in_wstrb;
  logic [XLEN-1:0] in_wdata;
  logic [XLEN-1:0] in_addr_al;

  assign in_off = in_ex_result[OW-1:0];

  // Low offset bits that must be zero for a naturally aligned access of
  // 2^size bytes. A doubleword on a 32-bit datapath is illegal regardless.
  assign in_size_mask = OW'((4'd1 << in_mem_size) - 4'd1);
  assign in_misalign  = (|(in_off & in_size_mask)) ||
                        ((in_mem_size == 2'd3) && (XLEN == 32));

  always_comb begin
    // NOTE: every variable written in a combinational block gets a value on
    // every path (here via the default arm) so no latch is inferred.
    case (in_mem_size)
      2'd0:    in_strb_base = NB'(1'b1);
      2'd1:    in_strb_base = NB'(2'b11);
      2'd2:    in_strb_base = NB'(4'hF);
      default: in_strb_base = '1;
    endcase
  end

  assign in_wstrb   = in_strb_base << in_off;
  assign in_wdata   = in_store_data << {in_off, 3'b000};
  assign in_addr_al = {in_ex_result[XLEN-1:OW], {OW{1'b0}}};

  // ---------------------------------------------------------------------------
  // Load alignment and extension from the returned word
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] keep;
  logic            sign;
  logic [XLEN-1:0] load_data;

  assign lane = dmem.dmem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0: begin
        keep = XLEN'(8'hFF);
        sign = lane[7];
      end
      2'd1: begin
        keep = XLEN'(16'hFFFF);
        sign = lane[15];
      end
      2'd2: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sign = lane[31];
      end
      default: begin
        keep = '1;
        sign = lane[XLEN-1];
      end
    endcase
  end

  // Bits above the access size are filled with the sign bit unless unsigned.
  assign load_data = (lane & keep) | ({XLEN{sign & ~uns_q}} & ~keep);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic accept;
  logic rsp_take;

  assign rsp_take = (state_q == WAIT) && dmem.dmem_rsp_valid;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;

    case (state_q)
      IDLE: in_ready = 1'b1;
      REQ:  if (dmem.dmem_req_ready) state_d = WAIT;
      WAIT: if (dmem.dmem_rsp_valid) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    accept = in_valid && in_ready;

    // A new instruction overrides the IDLE/retire transition, which gives
    // back-to-back throughput out of DONE.
    if (accept) begin
      if (!in_mem_en || in_misalign) state_d = DONE;
      else                           state_d = REQ;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state elements are updated with non-blocking assignments so every
    // flop samples the values from before the edge, independent of order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the datapath fields are reset as well because they drive the
    // outputs directly and must read as zero straight after reset.
    if (rst) begin
      pc_q        <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      misalign_q  <= 1'b0;
      is_load_q   <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
    end else if (accept) begin
      pc_q        <= in_pc;
      rf_waddr_q  <= in_rf_waddr;
      rf_wdata_q  <= in_ex_result;
      // A misaligned access never writes the register file.
      rf_we_q     <= in_rf_we && !(in_mem_en && in_misalign);
      misalign_q  <= in_mem_en && in_misalign;
      is_load_q   <= in_mem_en && !in_mem_we;
      off_q       <= in_off;
      size_q      <= in_mem_size;
      uns_q       <= in_mem_unsigned;
      req_addr_q  <= in_addr_al;
      req_we_q    <= in_mem_we;
      req_wstrb_q <= in_wstrb;
      req_wdata_q <= in_wdata;
    end else if (rsp_take) begin
      // Load: replace the address with the aligned data.
      // Store: the acknowledge completes it; stores never write back.
      if (is_load_q) rf_wdata_q <= load_data;
      else           rf_we_q    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmem.dmem_req_valid = (state_q == REQ);
  assign dmem.dmem_req_addr  = req_addr_q;
  assign dmem.dmem_req_we    = req_we_q;
  assign dmem.dmem_req_wstrb = req_wstrb_q;
  assign dmem.dmem_req_wdata = req_wdata_q;

  assign out_valid    = (state_q == DONE);
  assign out_pc       = pc_q;
  assign out_rf_we    = rf_we_q;
  assign out_rf_waddr = rf_waddr_q;
  assign out_rf_wdata = rf_wdata_q;
  assign out_misalign = misalign_q;

  // Forwarding: the held result in DONE; only the pending destination while a
  // load is outstanding (x0 is filtered by the consumer, not here).
  always_comb begin
    fwd_rf_we    = 1'b0;
    fwd_rf_waddr = '0;
    fwd_rf_wdata = '0;
    fwd_busy     = 1'b0;
    if (state_q == DONE) begin
      fwd_rf_we    = rf_we_q;
      fwd_rf_waddr = rf_waddr_q;
      fwd_rf_wdata = rf_wdata_q;
    end else if (((state_q == REQ) || (state_q == WAIT)) && is_load_q) begin
      fwd_busy     = 1'b1;
      fwd_rf_waddr = rf_waddr_q;
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_stage_hs
//
// Directed and randomized bench for mem_stage_hs (XLEN=64). The bench plays
// both EX, WB and the data memory. Inputs change on the falling edge and
// outputs are sampled 1 ns later. Expected values come from a byte-level
// model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_mem_stage_hs;

  localparam int XLEN  = 64;
  localparam int RF_AW = 5;
  localparam int PC_W  = 64;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [XLEN-1:0]  in_ex_result;
  logic             in_rf_we;
  logic [RF_AW-1:0] in_rf_waddr;
  logic             in_mem_en;
  logic             in_mem_we;
  logic [1:0]       in_mem_size;
  logic             in_mem_unsigned;
  logic [XLEN-1:0]  in_store_data;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic             out_rf_we;
  logic [RF_AW-1:0] out_rf_waddr;
  logic [XLEN-1:0]  out_rf_wdata;
  logic             out_misalign;
  logic             fwd_rf_we;
  logic [RF_AW-1:0] fwd_rf_waddr;
  logic [XLEN-1:0]  fwd_rf_wdata;
  logic             fwd_busy;

  int checks = 0;
  int errors = 0;

  mem_stage_hs_if #(.XLEN(XLEN)) dmem_if ();

  mem_stage_hs #(.XLEN(XLEN), .RF_AW(RF_AW), .PC_W(PC_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_ex_result    (in_ex_result),
    .in_rf_we        (in_rf_we),
    .in_rf_waddr     (in_rf_waddr),
    .in_mem_en       (in_mem_en),
    .in_mem_we       (in_mem_we),
    .in_mem_size     (in_mem_size),
    .in_mem_unsigned (in_mem_unsigned),
    .in_store_data   (in_store_data),
    .dmem            (dmem_if.master),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_rf_we       (out_rf_we),
    .out_rf_waddr    (out_rf_waddr),
    .out_rf_wdata    (out_rf_wdata),
    .out_misalign    (out_misalign),
    .fwd_rf_we       (fwd_rf_we),
    .fwd_rf_waddr    (fwd_rf_waddr),
    .fwd_rf_wdata    (fwd_rf_wdata),
    .fwd_busy        (fwd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mem_en;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] pc;
    logic [63:0] ex_result;
    logic [63:0] sdata;
    logic [63:0] rdata;
    logic        rf_we;
    logic [4:0]  waddr;
    int          req_dly;
    int          rsp_dly;
    int          out_dly;
  } instr_t;

  // ---------------------------------------------------------------------------
  // Comparisons
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (byte-level)
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] load_model(input logic [63:0] word,
                                             input int off, input int size,
                                             input logic uns);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
    if (!uns && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] strb_model(input int off, input int size);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < (1 << size); i++) s[off+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] wdata_model(input logic [63:0] d, input int off);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i + off < 8; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  function automatic instr_t mk(input logic mem_en, input logic we,
                                input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] sdata,
                                input logic [63:0] rdata);
    instr_t t;
    t.mem_en    = mem_en;
    t.we        = we;
    t.size      = size;
    t.uns       = uns;
    t.pc        = {32'h0, $urandom};
    t.ex_result = addr;
    t.sdata     = sdata;
    t.rdata     = rdata;
    t.rf_we     = 1'b1;
    t.waddr     = 5'($urandom_range(1, 31));
    t.req_dly   = 0;
    t.rsp_dly   = 0;
    t.out_dly   = 0;
    return t;
  endfunction

  task automatic scramble_inputs();
    in_pc           = {$urandom, $urandom};
    in_ex_result    = {$urandom, $urandom};
    in_store_data   = {$urandom, $urandom};
    in_rf_we        = 1'($urandom);
    in_rf_waddr     = 5'($urandom);
    in_mem_en       = 1'($urandom);
    in_mem_we       = 1'($urandom);
    in_mem_size     = 2'($urandom);
    in_mem_unsigned = 1'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  // One complete instruction from acceptance to retirement
  // ---------------------------------------------------------------------------
  task automatic do_instr(input instr_t ins, input string name);
    int          off;
    logic        mis;
    logic        is_load;
    logic        exp_we;
    logic        data_known;
    logic [63:0] exp_data;

    off        = int'(ins.ex_result[2:0]);
    mis        = ins.mem_en && ((off % (1 << ins.size)) != 0);
    is_load    = ins.mem_en && !ins.we && !mis;
    exp_we     = ins.rf_we && !(ins.mem_en && (mis || ins.we));
    data_known = !ins.mem_en || is_load;
    exp_data   = !ins.mem_en ? ins.ex_result
                             : load_model(ins.rdata, off, int'(ins.size), ins.uns);

    @(negedge clk);
    in_valid        = 1'b1;
    in_pc           = ins.pc;
    in_ex_result    = ins.ex_result;
    in_rf_we        = ins.rf_we;
    in_rf_waddr     = ins.waddr;
    in_mem_en       = ins.mem_en;
    in_mem_we       = ins.we;
    in_mem_size     = ins.size;
    in_mem_unsigned = ins.uns;
    in_store_data   = ins.sdata;
    out_ready       = 1'b0;
    #1;
    check({name, ".accept_ready"}, 64'(in_ready), 64'd1);

    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();

    if (ins.mem_en && !mis) begin
      for (int i = 0; i <= ins.req_dly; i++) begin
        dmem_if.dmem_req_ready = (i == ins.req_dly);
        #1;
        check({name, ".req_valid"}, 64'(dmem_if.dmem_req_valid), 64'd1);
        check({name, ".req_addr"},  dmem_if.dmem_req_addr, {ins.ex_result[63:3], 3'b000});
        check({name, ".req_we"},    64'(dmem_if.dmem_req_we), 64'(ins.we));
        if (ins.we) begin
          check({name, ".req_wstrb"}, 64'(dmem_if.dmem_req_wstrb),
                64'(strb_model(off, int'(ins.size))));
          check({name, ".req_wdata"}, dmem_if.dmem_req_wdata, wdata_model(ins.sdata, off));
        end
        check({name, ".req_fwd_busy"},  64'(fwd_busy), 64'(!ins.we));
        check({name, ".req_fwd_we"},    64'(fwd_rf_we), 64'd0);
        check({name, ".req_fwd_waddr"}, 64'(fwd_rf_waddr), ins.we ? 64'd0 : 64'(ins.waddr));
        check({name, ".req_out_valid"}, 64'(out_valid), 64'd0);
        check({name, ".req_in_ready"},  64'(in_ready), 64'd0);
        @(negedge clk);
      end
      dmem_if.dmem_req_ready = 1'b0;

      for (int j = 0; j <= ins.rsp_dly; j++) begin
        dmem_if.dmem_rsp_valid = (j == ins.rsp_dly);
        dmem_if.dmem_rsp_rdata = (j == ins.rsp_dly) ? ins.rdata : {$urandom, $urandom};
        #1;
        check({name, ".wait_req_valid"}, 64'(dmem_if.dmem_req_valid), 64'd0);
        check({name, ".wait_fwd_busy"},  64'(fwd_busy), 64'(!ins.we));
        check({name, ".wait_out_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
      end
      dmem_if.dmem_rsp_valid = 1'b0;
      dmem_if.dmem_rsp_rdata = {$urandom, $urandom};
    end

    for (int k = 0; k <= ins.out_dly; k++) begin
      out_ready = (k == ins.out_dly);
      #1;
      check({name, ".out_valid"},    64'(out_valid), 64'd1);
      check({name, ".out_pc"},       out_pc, ins.pc);
      check({name, ".out_rf_we"},    64'(out_rf_we), 64'(exp_we));
      check({name, ".out_rf_waddr"}, 64'(out_rf_waddr), 64'(ins.waddr));
      check({name, ".out_misalign"}, 64'(out_misalign), 64'(mis));
      check({name, ".done_req_valid"}, 64'(dmem_if.dmem_req_valid), 64'd0);
      check({name, ".fwd_we"},       64'(fwd_rf_we), 64'(exp_we));
      check({name, ".fwd_waddr"},    64'(fwd_rf_waddr), 64'(ins.waddr));
      check({name, ".fwd_busy"},     64'(fwd_busy), 64'd0);
      check({name, ".done_in_ready"}, 64'(in_ready), 64'(k == ins.out_dly));
      if (data_known) begin
        check({name, ".out_rf_wdata"}, out_rf_wdata, exp_data);
        check({name, ".fwd_wdata"},    fwd_rf_wdata, exp_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    check({name, ".retired_valid"}, 64'(out_valid), 64'd0);
    check({name, ".idle_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [63:0] LB_WORD = 64'h0080_FF7F_0000_0000;

  instr_t ins;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble_inputs();
    dmem_if.dmem_req_ready = 1'b0;
    dmem_if.dmem_rsp_valid = 1'b0;
    dmem_if.dmem_rsp_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.out_valid",  64'(out_valid), 64'd0);
    check("rst.req_valid",  64'(dmem_if.dmem_req_valid), 64'd0);
    check("rst.req_addr",   dmem_if.dmem_req_addr, 64'd0);
    check("rst.req_wstrb",  64'(dmem_if.dmem_req_wstrb), 64'd0);
    check("rst.out_pc",     out_pc, 64'd0);
    check("rst.out_wdata",  out_rf_wdata, 64'd0);
    check("rst.fwd_busy",   64'(fwd_busy), 64'd0);
    check("rst.fwd_we",     64'(fwd_rf_we), 64'd0);
    check("rst.in_ready",   64'(in_ready), 64'd1);

    // Three back-to-back ALU results, WB always ready
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid        = (i < 3);
      in_mem_en       = 1'b0;
      in_rf_we        = 1'b1;
      in_rf_waddr     = 5'(i + 1);
      in_pc           = 64'(32'h400 + 4 * i);
      in_ex_result    = 64'(8'h11 * (i + 1));
      #1;
      check("b2b.in_ready", 64'(in_ready), 64'd1);
      if (i > 0) begin
        check("b2b.out_valid", 64'(out_valid), 64'd1);
        check("b2b.out_wdata", out_rf_wdata, 64'(8'h11 * i));
        check("b2b.out_waddr", 64'(out_rf_waddr), 64'(i));
      end else begin
        check("b2b.first_idle", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    check("b2b.drained", 64'(out_valid), 64'd0);

    // Byte loads from one word
    do_instr(mk(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, LB_WORD), "lb_1003");
    do_instr(mk(1'b1, 1'b0, 2'd0, 1'b0, 64'h1006, 64'h0, LB_WORD), "lb_1006");
    do_instr(mk(1'b1, 1'b0, 2'd0, 1'b1, 64'h1006, 64'h0, LB_WORD), "lbu_1006");

    // Halfword store, write acknowledge suppresses write-back
    do_instr(mk(1'b1, 1'b1, 2'd1, 1'b0, 64'h1002, 64'hABCD, 64'h0), "sh_1002");

    // Misaligned word load
    do_instr(mk(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'h0, LB_WORD), "lw_mis");

    // ALU result to x0 is still forwarded
    ins = mk(1'b0, 1'b0, 2'd0, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0, 64'h0);
    ins.waddr = 5'd0;
    do_instr(ins, "alu_x0");

    // Long stalls on both memory handshakes and on WB
    ins = mk(1'b1, 1'b0, 2'd3, 1'b0, 64'h3008, 64'h0, 64'h8123_4567_89AB_CDEF);
    ins.req_dly = 3;
    ins.rsp_dly = 3;
    ins.out_dly = 2;
    do_instr(ins, "ld_stall");

    // Reset while waiting for a load response, then a stale response
    @(negedge clk);
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b0; in_mem_size = 2'd2;
    in_ex_result = 64'h2000; in_rf_we = 1'b1; in_rf_waddr = 5'd7; in_pc = 64'h88;
    @(negedge clk);
    in_valid = 1'b0;
    dmem_if.dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_if.dmem_req_ready = 1'b0;
    #1;
    check("rstw.in_wait_busy", 64'(fwd_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw.out_valid", 64'(out_valid), 64'd0);
    check("rstw.req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
    check("rstw.fwd_busy",  64'(fwd_busy), 64'd0);
    check("rstw.out_pc",    out_pc, 64'd0);
    check("rstw.in_ready",  64'(in_ready), 64'd1);
    dmem_if.dmem_rsp_valid = 1'b1;
    dmem_if.dmem_rsp_rdata = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    dmem_if.dmem_rsp_valid = 1'b0;
    #1;
    check("rstw.stale_valid", 64'(out_valid), 64'd0);
    check("rstw.stale_wdata", out_rf_wdata, 64'd0);
    @(negedge clk);
    #1;
    check("rstw.stale_valid2", 64'(out_valid), 64'd0);

    // Randomized mix
    for (int t = 0; t < 40; t++) begin
      ins = mk($urandom_range(0, 9) < 7, 1'($urandom), 2'($urandom), 1'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      ins.rf_we   = 1'($urandom);
      ins.waddr   = 5'($urandom);
      ins.req_dly = $urandom_range(0, 3);
      ins.rsp_dly = $urandom_range(0, 3);
      ins.out_dly = $urandom_range(0, 2);
      do_instr(ins, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
